// File: rtl/peripheral_spi_master_param.sv
// SPI master peripheral for the J1 I/O bus. It has a configurable word width,
// SPI mode, sck divider and slave-select count, and stores received words in
// a small RX FIFO. A single engine FSM produces sck, mosi and ss. Every
// output that leaves the block is registered.
module peripheral_spi_master_param #(
   parameter int DATA_W     = 8,
   parameter int N_SS       = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_RST    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       d_in,
   input  logic              cs,
   input  logic [3:0]        addr,
   input  logic              rd,
   input  logic              wr,
   output logic [15:0]       d_out,
   input  logic              miso,
   output logic              mosi,
   output logic              sck,
   output logic [N_SS-1:0]   ss
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int HALF_W = 6;
   localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [3:0]          ctrl_q, ctrl_d;
   logic [7:0]          div_q, div_d;
   logic [N_SS-1:0]     ssel_q, ssel_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [HALF_W-1:0]   half_q, half_d;
   logic [7:0]          div_l_q, div_l_d;
   logic                cpha_l_q, cpha_l_d;
   logic                cpol_l_q, cpol_l_d;
   logic                lsb_l_q, lsb_l_d;
   logic                auto_l_q, auto_l_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic [N_SS-1:0]     ss_q, ss_d;
   logic                ovr_q, ovr_d;
   logic                col_q, col_d;
   logic [15:0]         dout_q, dout_d;
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [PTR_W-1:0]    rptr_q, rptr_d;
   logic [CNT_W-1:0]    fcount_q, fcount_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

   logic wr_en, rd_en;
   logic wr_tx, wr_ctrl, wr_div, wr_ssel, wr_srst;
   logic rd_rx, rd_status;
   logic busy, full, empty, pop, push, push_ok;
   logic half_done, lead_ev, trail_ev, do_shift, do_sample, auto_now;
   logic [15:0] rx_head;
   logic [15:0] status_word;
   logic unused_d_in;

   assign wr_en     = cs & wr;
   assign rd_en     = cs & rd;
   assign wr_tx     = wr_en && (addr == 4'h0);
   assign wr_ctrl   = wr_en && (addr == 4'h2);
   assign wr_div    = wr_en && (addr == 4'h4);
   assign wr_ssel   = wr_en && (addr == 4'h6);
   assign wr_srst   = wr_en && (addr == 4'hC);
   assign rd_rx     = rd_en && (addr == 4'h8);
   assign rd_status = rd_en && (addr == 4'hA);

   assign busy      = (state_q != S_IDLE);
   assign full      = (fcount_q == CNT_W'(FIFO_DEPTH));
   assign empty     = (fcount_q == '0);
   assign half_done = (cnt_q == div_l_q);
   assign unused_d_in = ^d_in;

   assign d_out = dout_q;
   assign mosi  = mosi_q;
   assign sck   = sck_q;
   assign ss    = ss_q;

   function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic lsb,
                                                  input logic b);
      logic [DATA_W:0] t;
      if (lsb) begin
         t = {b, v};
         return t[DATA_W:1];
      end
      t = {v, b};
      return t[DATA_W-1:0];
   endfunction

   // Next-state logic: register writes, the engine FSM, the FIFO and read data
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      div_d    = div_q;
      ssel_d   = ssel_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      div_l_d  = div_l_q;
      cpha_l_d = cpha_l_q;
      cpol_l_d = cpol_l_q;
      lsb_l_d  = lsb_l_q;
      auto_l_d = auto_l_q;
      tx_sh_d  = tx_sh_q;
      rx_sh_d  = rx_sh_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      ovr_d    = ovr_q;
      col_d    = col_q;
      dout_d   = dout_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      fcount_d = fcount_q;
      lead_ev  = 1'b0;
      trail_ev = 1'b0;
      push     = 1'b0;
      rx_head  = '0;
      rx_head[DATA_W-1:0] = mem_q[rptr_q];
      status_word = {6'd0, 5'(fcount_q), col_q, ovr_q, full, ~empty, busy};

      if (wr_ctrl) ctrl_d = d_in[3:0];
      if (wr_div)  div_d  = d_in[7:0];
      if (wr_ssel) ssel_d = d_in[N_SS-1:0];

      // Mode, divider and word are frozen at start so mid-transfer writes
      // to CTRL or DIV only take effect on the next transfer.
      unique case (state_q)
         S_IDLE: begin
            sck_d = ctrl_q[1];
            if (wr_tx) begin
               state_d  = S_SETUP;
               cnt_d    = '0;
               half_d   = '0;
               div_l_d  = div_q;
               cpha_l_d = ctrl_q[0];
               cpol_l_d = ctrl_q[1];
               lsb_l_d  = ctrl_q[2];
               auto_l_d = ctrl_q[3];
               rx_sh_d  = '0;
               tx_sh_d  = d_in[DATA_W-1:0];
               if (!ctrl_q[0]) begin
                  mosi_d  = first_bit(d_in[DATA_W-1:0], ctrl_q[2]);
                  tx_sh_d = shift_out(d_in[DATA_W-1:0], ctrl_q[2]);
               end
            end
         end
         S_SETUP: begin
            if (half_done) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               half_d  = '0;
               sck_d   = ~cpol_l_q;
               lead_ev = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_SHIFT: begin
            if (half_done) begin
               cnt_d = '0;
               if (half_q == LAST_HALF) begin
                  state_d = S_HOLD;
               end else begin
                  half_d = half_q + HALF_W'(1);
                  sck_d  = ~sck_q;
                  if (half_q[0]) lead_ev = 1'b1;
                  else           trail_ev = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (half_done) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               push    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      do_shift  = cpha_l_q ? lead_ev : trail_ev;
      do_sample = cpha_l_q ? trail_ev : lead_ev;
      if (do_shift) begin
         mosi_d  = first_bit(tx_sh_q, lsb_l_q);
         tx_sh_d = shift_out(tx_sh_q, lsb_l_q);
      end
      if (do_sample) rx_sh_d = shift_in(rx_sh_q, lsb_l_q, miso);

      // A full FIFO still accepts a push when the same cycle pops a word.
      pop     = rd_rx && !empty;
      push_ok = push && (!full || pop);
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop)     rptr_d = rptr_q + PTR_W'(1);
      fcount_d = fcount_q + CNT_W'(push_ok) - CNT_W'(pop);

      ovr_d = (ovr_q & ~rd_status) | (push & ~push_ok);
      col_d = (col_q & ~rd_status) | (wr_tx & busy);

      if (rd_en) begin
         case (addr)
            4'h8:    dout_d = empty ? 16'd0 : rx_head;
            4'hA:    dout_d = status_word;
            default: dout_d = 16'd0;
         endcase
      end

      auto_now = (state_q == S_IDLE) ? ctrl_q[3] : auto_l_q;
      ss_d = (auto_now && (state_d == S_IDLE)) ? '1 : ~ssel_q;

      // Soft reset flushes the engine and FIFO but keeps CTRL, DIV and SSEL.
      if (wr_srst) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         half_d   = '0;
         tx_sh_d  = '0;
         rx_sh_d  = '0;
         sck_d    = ctrl_q[1];
         mosi_d   = 1'b0;
         ss_d     = '1;
         ovr_d    = 1'b0;
         col_d    = 1'b0;
         dout_d   = '0;
         wptr_d   = '0;
         rptr_d   = '0;
         fcount_d = '0;
      end
   end

   // State registers for the register file, engine and FIFO control
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ctrl_q   <= '0;
         div_q    <= 8'(DIV_RST);
         ssel_q   <= '0;
         cnt_q    <= '0;
         half_q   <= '0;
         div_l_q  <= '0;
         cpha_l_q <= 1'b0;
         cpol_l_q <= 1'b0;
         lsb_l_q  <= 1'b0;
         auto_l_q <= 1'b0;
         tx_sh_q  <= '0;
         rx_sh_q  <= '0;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         ss_q     <= '1;
         ovr_q    <= 1'b0;
         col_q    <= 1'b0;
         dout_q   <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         fcount_q <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         div_q    <= div_d;
         ssel_q   <= ssel_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         div_l_q  <= div_l_d;
         cpha_l_q <= cpha_l_d;
         cpol_l_q <= cpol_l_d;
         lsb_l_q  <= lsb_l_d;
         auto_l_q <= auto_l_d;
         tx_sh_q  <= tx_sh_d;
         rx_sh_q  <= rx_sh_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         ss_q     <= ss_d;
         ovr_q    <= ovr_d;
         col_q    <= col_d;
         dout_q   <= dout_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         fcount_q <= fcount_d;
      end
   end

   // FIFO storage; stale contents are harmless because the pointers gate them
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= rx_sh_q;
   end

endmodule
